rsv_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the PC and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words in a small FIFO and presents {instruction, PC} to decode with a valid/ready handshake.
- Takes redirects from execute (branch/jump): flushes buffered words and discards in-flight responses.

---
 rtl/rsv_fetch.sv | 196 +++++++++++++++++++
 tb/tb_rsv_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsv_fetch.sv
// ---------------------------------------------------------------------------
// rsv_fetch -- instruction fetch stage feeding the decoder.
//
// Owns the fetch PC, issues word requests to instruction memory over a
// req/gnt + rvalid interface, buffers returned words in a small FIFO and
// hands {instruction, PC} to decode with a valid/ready handshake. A redirect
// from execute flushes the buffer and marks every in-flight response for
// discard.
//
// Optional build macro: RSV_FETCH_ALIGN_CHECK_EN
//   defined   : adds fetch_misalign_o; a misaligned redirect target raises the
//               flag and stalls fetch until the next aligned redirect/reset.
//   undefined : redirect target bits [1:0] are ignored (forced to 0).
//
// Ports:
//   clk_i, reset_i        clock (rising edge), synchronous active-high reset
//   redirect_valid_i/_pc_i redirect request and target from execute
//   imem_req_o/addr_o     request valid / word address to instruction memory
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response, no backpressure
//   inst_valid_o/inst_o/inst_pc_o  FIFO head presented to decode
//   inst_ready_i          decode consumes the head when valid && ready
//   fetch_misalign_o      (RSV_FETCH_ALIGN_CHECK_EN only) misaligned target
// ---------------------------------------------------------------------------
module rsv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
`ifdef RSV_FETCH_ALIGN_CHECK_EN
  output logic        fetch_misalign_o,
`endif
  input  logic        inst_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic        stall;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // The target is always word aligned; the low bits only feed the
  // optional misalignment flag.
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

`ifdef RSV_FETCH_ALIGN_CHECK_EN
  logic misalign_reg, misalign_next;

  always_comb begin
    misalign_next = misalign_reg;
    if (redirect_valid_i) begin
      misalign_next = |redirect_pc_i[1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end

  assign stall            = misalign_reg;
  assign fetch_misalign_o = misalign_reg;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign stall          = 1'b0;
`endif

  // Requests are credited against FIFO space: every outstanding request owns
  // a slot, so a response can always be pushed. A same-cycle pop does not
  // free credit, which keeps the request path independent of inst_ready_i.
  assign imem_req_o   = !reset_i && !redirect_valid_i && !stall &&
                        ((outstanding_reg + count_reg) < DEPTH_C);
  assign imem_addr_o  = pc_reg;
  assign accept       = imem_req_o && imem_gnt_i;

  assign inst_valid_o = (count_reg != '0);
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr_reg] : 32'h0;
  assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr_reg]   : 32'h0;

  // Responses are dropped while discards are pending or when a redirect
  // lands in the same cycle.
  assign push = imem_rvalid_i && !redirect_valid_i && (discard_reg == '0);
  assign pop  = inst_valid_o && inst_ready_i && !redirect_valid_i;

  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(imem_rvalid_i);
    discard_next     = discard_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (accept) begin
      pc_next = pc_reg + 32'd4;
    end

    if (imem_rvalid_i && (discard_reg != '0)) begin
      discard_next = discard_reg - CNT_W'(1);
    end

    if (push) begin
      resp_pc_next = resp_pc_reg + 32'd4;
      wr_ptr_next  = wr_ptr_reg + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    if (redirect_valid_i) begin
      pc_next      = redirect_target;
      resp_pc_next = redirect_target;
      // Every request still in flight after this cycle belongs to the old
      // stream. Pending discards are part of that in-flight set, so the
      // outstanding count is the complete new discard total.
      discard_next = outstanding_next;
      count_next   = '0;
      rd_ptr_next  = '0;
      wr_ptr_next  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // Buffer storage needs no reset: the head is gated by inst_valid_o.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      inst_mem[wr_ptr_reg] <= imem_rdata_i;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  // The credit scheme must never let a push land on a full buffer
  // unless the head leaves in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push && !pop && (count_reg == DEPTH_C)));
    end
  end

endmodule

// File: tb/tb_rsv_fetch.sv
// ---------------------------------------------------------------------------
// tb_rsv_fetch -- directed bench for rsv_fetch (default parameters).
// A small memory responder queues granted addresses and returns
// addr ^ 32'h5A5A_0000 one cycle later (or later while hold is set).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_rsv_fetch;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef RSV_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  int checks = 0;
  int errors = 0;
  logic hold = 1'b0;
  logic [31:0] q_addr [$];

  rsv_fetch dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
`ifdef RSV_FETCH_ALIGN_CHECK_EN
    .fetch_misalign_o (fetch_misalign_o),
`endif
    .inst_ready_i     (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: in order, >=1 cycle after grant, cleared by reset.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      if (reset_i) q_addr.delete();
      else if (imem_req_o && imem_gnt_i) q_addr.push_back(imem_addr_o);
      @(posedge clk_i);
      #2;
      if (!hold && !reset_i && q_addr.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mw(q_addr.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (3) step();
    smp();
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
`ifdef RSV_FETCH_ALIGN_CHECK_EN
    chk("rst_misalign", fetch_misalign_o, 0);
`endif
    $display("reset checked");

    // Streaming fetch, gnt=1, 1-cycle response, ready=1
    step(); reset_i = 1'b0; smp();
    chk("A_req", imem_req_o, 1); chk("A_addr", imem_addr_o, 32'h0); chk("A_valid", inst_valid_o, 0);
    step(); smp();
    chk("B_req", imem_req_o, 1); chk("B_addr", imem_addr_o, 32'h4); chk("B_valid", inst_valid_o, 0);
    step(); smp();
    chk("C_valid", inst_valid_o, 1); chk("C_pc", inst_pc_o, 32'h0); chk("C_inst", inst_o, mw(32'h0));
    chk("C_req_credit", imem_req_o, 0);
    step(); smp();
    chk("D_pc", inst_pc_o, 32'h4); chk("D_inst", inst_o, mw(32'h4)); chk("D_addr", imem_addr_o, 32'h8);
    step(); imem_gnt_i = 1'b0; smp();
    chk("E_valid", inst_valid_o, 0); chk("E_rvalid", imem_rvalid_i, 1); chk("E_addr", imem_addr_o, 32'hC);
    step(); smp();
    chk("F_pc", inst_pc_o, 32'h8); chk("F_inst", inst_o, mw(32'h8));
    $display("stream 0x0/0x4/0x8 checked");

    // Grant withheld for 3 cycles: address holds, no responses
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("nognt_req", imem_req_o, 1); chk("nognt_addr", imem_addr_o, 32'hC);
      chk("nognt_rvalid", imem_rvalid_i, 0); chk("nognt_valid", inst_valid_o, 0);
    end
    $display("grant stall checked");

    // Backpressure: exactly two requests, then req drops until drained
    step(); imem_gnt_i = 1'b1; inst_ready_i = 1'b0; smp();
    chk("J_addr", imem_addr_o, 32'hC); chk("J_req", imem_req_o, 1);
    step(); smp();
    chk("K_addr", imem_addr_o, 32'h10); chk("K_req", imem_req_o, 1);
    step(); smp();
    chk("L_req", imem_req_o, 0); chk("L_pc", inst_pc_o, 32'hC);
    step(); smp();
    chk("M_req", imem_req_o, 0); chk("M_inst", inst_o, mw(32'hC));
    step(); smp();
    chk("N_req", imem_req_o, 0);
    step(); inst_ready_i = 1'b1; smp();
    chk("O_pc", inst_pc_o, 32'hC); chk("O_req", imem_req_o, 0);
    step(); imem_gnt_i = 1'b0; smp();
    chk("P_pc", inst_pc_o, 32'h10); chk("P_inst", inst_o, mw(32'h10)); chk("P_addr", imem_addr_o, 32'h14);
    $display("backpressure checked");

    // Two outstanding requests then redirect to 0x100
    step(); imem_gnt_i = 1'b1; hold = 1'b1; smp();
    chk("Q_valid", inst_valid_o, 0); chk("Q_addr", imem_addr_o, 32'h14);
    step(); smp();
    chk("R_addr", imem_addr_o, 32'h18);
    step(); smp();
    chk("S_req", imem_req_o, 0); chk("S_rvalid", imem_rvalid_i, 0);
    step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h100; smp();
    chk("T_req_redirect", imem_req_o, 0);
    step(); redirect_valid_i = 1'b0; hold = 1'b0; smp();
    chk("U_rvalid", imem_rvalid_i, 1); chk("U_valid", inst_valid_o, 0); chk("U_req", imem_req_o, 0);
    step(); smp();
    chk("V_rvalid", imem_rvalid_i, 1); chk("V_valid", inst_valid_o, 0);
    chk("V_req", imem_req_o, 1); chk("V_addr", imem_addr_o, 32'h100);
    step(); smp();
    chk("W_valid", inst_valid_o, 0); chk("W_addr", imem_addr_o, 32'h104);
    step(); imem_gnt_i = 1'b0; smp();
    chk("X_valid", inst_valid_o, 1); chk("X_pc", inst_pc_o, 32'h100); chk("X_inst", inst_o, mw(32'h100));
    step(); smp();
    chk("Y_pc", inst_pc_o, 32'h104); chk("Y_addr", imem_addr_o, 32'h108);
    $display("redirect with outstanding checked");

    // Redirect coinciding with a response and an attempted pop
    step(); imem_gnt_i = 1'b1; inst_ready_i = 1'b0; smp();
    chk("Z_valid", inst_valid_o, 0); chk("Z_addr", imem_addr_o, 32'h108);
    step(); smp();
    chk("a_addr", imem_addr_o, 32'h10C);
    step(); inst_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h200; smp();
    chk("b_valid", inst_valid_o, 1); chk("b_pc", inst_pc_o, 32'h108);
    chk("b_rvalid", imem_rvalid_i, 1); chk("b_req", imem_req_o, 0);
    step(); redirect_valid_i = 1'b0; smp();
    chk("c_valid", inst_valid_o, 0); chk("c_addr", imem_addr_o, 32'h200); chk("c_req", imem_req_o, 1);
    step(); imem_gnt_i = 1'b0; smp();
    chk("d_valid", inst_valid_o, 0); chk("d_addr", imem_addr_o, 32'h204);
    step(); smp();
    chk("e_pc", inst_pc_o, 32'h200); chk("e_inst", inst_o, mw(32'h200));
    $display("redirect on response checked");

    // Fill FIFO then reset
    step(); imem_gnt_i = 1'b1; inst_ready_i = 1'b0; smp();
    chk("f_addr", imem_addr_o, 32'h204); chk("f_valid", inst_valid_o, 0);
    step(); smp();
    chk("g_addr", imem_addr_o, 32'h208);
    step(); smp();
    chk("h_req", imem_req_o, 0); chk("h_pc", inst_pc_o, 32'h204);
    step(); smp();
    chk("i_full_req", imem_req_o, 0); chk("i_pc", inst_pc_o, 32'h204); chk("i_valid", inst_valid_o, 1);
    step(); reset_i = 1'b1; smp();
    step(); smp();
    chk("k_valid", inst_valid_o, 0); chk("k_req", imem_req_o, 0);
    chk("k_inst", inst_o, 0); chk("k_pc", inst_pc_o, 0);
    step(); reset_i = 1'b0; imem_gnt_i = 1'b0; smp();
    chk("l_req", imem_req_o, 1); chk("l_addr", imem_addr_o, 32'h0);
    $display("reset with full FIFO checked");

    // Misaligned redirect target
    step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h102; smp();
    chk("m_req", imem_req_o, 0);
    for (int i = 0; i < 2; i++) begin
      step(); redirect_valid_i = 1'b0; smp();
`ifdef RSV_FETCH_ALIGN_CHECK_EN
      chk("mis_flag", fetch_misalign_o, 1); chk("mis_req", imem_req_o, 0);
`else
      chk("mask_req", imem_req_o, 1); chk("mask_addr", imem_addr_o, 32'h100);
`endif
    end
    step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h104; smp();
    chk("p_req", imem_req_o, 0);
    step(); redirect_valid_i = 1'b0; smp();
    chk("q_req", imem_req_o, 1); chk("q_addr", imem_addr_o, 32'h104);
`ifdef RSV_FETCH_ALIGN_CHECK_EN
    chk("q_flag", fetch_misalign_o, 0);
`endif
    $display("misaligned redirect checked");

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
